cnt_tracker: RTL and testbench

//  Receive-side monitor for the enable-driven up-counter output (out[W-1:0], en).

---
 rtl/cnt_tracker.sv | 112 +++++++++++
 tb/tb_cnt_tracker.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/cnt_tracker.sv
// Receive-side monitor for an enable-driven up-counter: tracks expected count plus a
// complementary down-count shadow. Optional macro CNT_TRACK_RESYNC_EN makes ERROR recoverable.
module cnt_tracker #(
    parameter int W        = 4,
    parameter int LOCK_CNT = 4,
    parameter int ERR_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [W-1:0]     obs,
    output logic             locked,
    output logic             err,
    output logic [ERR_W-1:0] err_cnt,
    output logic [W-1:0]     exp_val,
    output logic             inv_ok,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        SYNC  = 2'd0,
        TRACK = 2'd1,
        ERROR = 2'd2
    } state_t;

    localparam logic [W-1:0] MAX  = '1;
    localparam logic [7:0]   LOCK = 8'(LOCK_CNT);

    state_t             st_q, st_d;
    logic [W-1:0]       exp_q, exp_d;
    logic [W-1:0]       shd_q, shd_d;
    logic [7:0]         match_q, match_d;
    logic [7:0]         match_inc;
    logic               locked_q, locked_d;
    logic               err_q, err_d;
    logic [ERR_W-1:0]   err_cnt_q, err_cnt_d;
    logic [W-1:0]       step;
    logic [W-1:0]       sync_val;

    assign step      = en ? W'(1) : '0;
    assign sync_val  = obs + step;
    assign match_inc = (match_q >= LOCK) ? LOCK : match_q + 8'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q      <= SYNC;
            exp_q     <= '0;
            shd_q     <= MAX;
            match_q   <= '0;
            locked_q  <= 1'b0;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            st_q      <= st_d;
            exp_q     <= exp_d;
            shd_q     <= shd_d;
            match_q   <= match_d;
            locked_q  <= locked_d;
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    // exp and shd advance together in every state except SYNC, which reloads both from obs.
    always_comb begin
        st_d      = st_q;
        exp_d     = exp_q + step;
        shd_d     = shd_q - step;
        match_d   = match_q;
        locked_d  = locked_q;
        err_d     = err_q;
        err_cnt_d = err_cnt_q;
        case (st_q)
            SYNC: begin
                exp_d    = sync_val;
                shd_d    = MAX - sync_val;
                match_d  = '0;
                locked_d = 1'b0;
                st_d     = TRACK;
            end
            TRACK: begin
                if (obs == exp_q) begin
                    match_d = match_inc;
                    if (match_inc >= LOCK) locked_d = 1'b1;
                end else begin
                    err_d     = 1'b1;
                    err_cnt_d = (err_cnt_q == '1) ? err_cnt_q : err_cnt_q + ERR_W'(1);
                    locked_d  = 1'b0;
                    match_d   = '0;
                    st_d      = ERROR;
                end
            end
            ERROR: begin
`ifdef CNT_TRACK_RESYNC_EN
                err_d = 1'b0;
                st_d  = SYNC;
`else
                st_d  = ERROR;
`endif
            end
            default: st_d = SYNC;
        endcase
    end

    assign locked  = locked_q;
    assign err     = err_q;
    assign err_cnt = err_cnt_q;
    assign exp_val = exp_q;
    assign inv_ok  = (exp_q == MAX - shd_q);
    assign state   = st_q;

endmodule

// File: tb/tb_cnt_tracker.sv
// Directed self-checking bench for cnt_tracker; expectations follow the resync macro setting.
module tb_cnt_tracker;

    logic       clk;
    logic       rst;
    logic       en;
    logic [3:0] obs;
    logic       locked, err, inv_ok;
    logic [7:0] err_cnt;
    logic [3:0] exp_val;
    logic [1:0] state;

    logic       locked2, err2, inv_ok2;
    logic [1:0] err_cnt2;
    logic [3:0] exp_val2;
    logic [1:0] state2;

    logic [3:0] cnt;
    logic [3:0] exp_q[$];
    int         n_checks = 0;
    int         n_fail   = 0;

    cnt_tracker #(.W(4), .LOCK_CNT(4), .ERR_W(8)) dut (
        .clk(clk), .rst(rst), .en(en), .obs(obs),
        .locked(locked), .err(err), .err_cnt(err_cnt),
        .exp_val(exp_val), .inv_ok(inv_ok), .state(state)
    );

    cnt_tracker #(.W(4), .LOCK_CNT(4), .ERR_W(2)) dut2 (
        .clk(clk), .rst(rst), .en(en), .obs(obs),
        .locked(locked2), .err(err2), .err_cnt(err_cnt2),
        .exp_val(exp_val2), .inv_ok(inv_ok2), .state(state2)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    // inputs change at posedge+1; outputs are sampled there too
    task automatic tick();
        @(posedge clk);
        #1;
        check("inv_ok", inv_ok, 1);
        check("inv_ok2", inv_ok2, 1);
    endtask

    task automatic drive(input logic e, input logic [3:0] o);
        en  = e;
        obs = o;
        tick();
        if (e) cnt = cnt + 4'd1;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_state"}, state, 0);
        check({tag, "_exp"}, exp_val, 0);
        check({tag, "_locked"}, locked, 0);
        check({tag, "_err"}, err, 0);
        check({tag, "_errcnt"}, err_cnt, 0);
        check({tag, "_inv"}, inv_ok, 1);
        check({tag, "_errcnt2"}, err_cnt2, 0);
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        #2;
        check_reset_vals(tag);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cnt = 4'd0;
    endtask

    initial begin
        logic [3:0] want;
        logic [3:0] flip;
        rst = 1'b0;
        en  = 1'b0;
        obs = 4'd0;
        cnt = 4'd0;
        #1;

        // test 1: free run with wrap, lock after 5th cycle
        do_reset("rst1");
        for (int i = 1; i <= 20; i++) exp_q.push_back(4'(i));
        for (int i = 1; i <= 20; i++) begin
            drive(1'b1, cnt);
            want = exp_q.pop_front();
            check("t1_exp", exp_val, want);
            check("t1_err", err, 0);
            check("t1_state", state, 1);
            check("t1_locked", locked, (i >= 5) ? 1 : 0);
        end

        // test 2: hold at 5 with en=0
        drive(1'b1, cnt);
        check("t2_exp5", exp_val, 5);
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, cnt);
            check("t2_exp", exp_val, 5);
            check("t2_locked", locked, 1);
            check("t2_err", err, 0);
        end

        // test 3: mismatch at exp=7
        drive(1'b1, cnt);
        drive(1'b1, cnt);
        check("t3_exp7", exp_val, 7);
        drive(1'b1, 4'd3);
        check("t3_err", err, 1);
        check("t3_state", state, 2);
        check("t3_errcnt", err_cnt, 1);
        check("t3_locked", locked, 0);
        check("t3_exp", exp_val, 8);

        // test 4: recovery (or not) with the counter consistent
        drive(1'b1, cnt);
        check("t4_exp", exp_val, 9);
        check("t4_errcnt", err_cnt, 1);
`ifdef CNT_TRACK_RESYNC_EN
        check("t4_state_sync", state, 0);
        check("t4_err_sync", err, 0);
        drive(1'b0, cnt);
        check("t4_state_track", state, 1);
        check("t4_exp9", exp_val, 9);
        for (int i = 1; i <= 4; i++) begin
            drive(1'b0, cnt);
            check("t4_locked", locked, (i >= 4) ? 1 : 0);
            check("t4_err", err, 0);
        end
        check("t4_errcnt_kept", err_cnt, 1);
`else
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, cnt);
            check("t4_state_err", state, 2);
            check("t4_err_sticky", err, 1);
            check("t4_locked", locked, 0);
            check("t4_exp_hold", exp_val, 9);
        end
`endif

        // test 5: repeated mismatches, err_cnt saturation on a 2-bit counter
        do_reset("rst5");
        for (int k = 1; k <= 5; k++) begin
            drive(1'b0, cnt);
            flip = 4'($urandom_range(1, 15));
            drive(1'b0, cnt ^ flip);
            drive(1'b0, cnt);
`ifdef CNT_TRACK_RESYNC_EN
            check("t5_errcnt", err_cnt, k);
            check("t5_errcnt_sat", err_cnt2, (k > 3) ? 3 : k);
            check("t5_err_cleared", err, 0);
            check("t5_state", state, 0);
`else
            check("t5_errcnt", err_cnt, 1);
            check("t5_errcnt2", err_cnt2, 1);
            check("t5_err", err, 1);
            check("t5_state", state, 2);
`endif
        end

        // test 6: async reset mid-TRACK at exp=0xC
        do_reset("rst6");
        for (int i = 0; i < 12; i++) drive(1'b1, cnt);
        check("t6_exp", exp_val, 12);
        check("t6_state", state, 1);
        check("t6_locked", locked, 1);
        en  = 1'b1;
        rst = 1'b1;
        #2;
        check_reset_vals("t6_async");
        rst = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
